// File: rtl/sqrt_request_pkg.sv
// ---------------------------------------------------------------------------
// sqrt_request_pkg
// Shared tracking package: FSM state encoding, default coordinate width and
// the radicand-width helper used by sqrt_request and its dist_sq datapath.
// ---------------------------------------------------------------------------
package sqrt_request_pkg;

    // Default pixel coordinate width.
    localparam int COORD_W_DEF = 10;

    // dx^2 + dy^2 needs 2*W bits per square plus one carry bit for the sum.
    function automatic int rad_w(input int coord_w);
        return 2 * coord_w + 1;
    endfunction

    localparam int RAD_W_DEF = rad_w(COORD_W_DEF);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DIFF   = 3'd1,
        ST_SQUARE = 3'd2,
        ST_LAUNCH = 3'd3,
        ST_WAIT   = 3'd4
    } state_e;

    // Index of each coordinate inside a packed [3:0][COORD_W-1:0] bundle.
    localparam int IDX_TX = 3;
    localparam int IDX_TY = 2;
    localparam int IDX_LX = 1;
    localparam int IDX_LY = 0;

endpackage

// File: rtl/sqrt_request_dist_sq.sv
// ---------------------------------------------------------------------------
// dist_sq
// Distance-squared datapath: registered absolute differences followed by a
// registered square-and-sum at full width (no truncation or saturation).
//
// Ports:
//   clk, reset      clock / asynchronous active-low reset
//   diff_en         load dx/dy from the coordinate inputs
//   sq_en           load radicand = dx*dx + dy*dy
//   a_x, a_y        target position
//   b_x, b_y        light position
//   radicand        registered dx^2 + dy^2, held until the next sq_en
// ---------------------------------------------------------------------------
module dist_sq
    import sqrt_request_pkg::*;
#(
    parameter int COORD_W = COORD_W_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 diff_en,
    input  logic                 sq_en,
    input  logic [COORD_W-1:0]   a_x,
    input  logic [COORD_W-1:0]   a_y,
    input  logic [COORD_W-1:0]   b_x,
    input  logic [COORD_W-1:0]   b_y,
    output logic [2*COORD_W:0]   radicand
);

    localparam int RAD_W = rad_w(COORD_W);

    logic [COORD_W-1:0] dx_q, dx_d;
    logic [COORD_W-1:0] dy_q, dy_d;
    logic [RAD_W-1:0]   rad_q, rad_d;

    always_comb begin
        dx_d  = dx_q;
        dy_d  = dy_q;
        rad_d = rad_q;
        if (diff_en) begin
            // Subtract the smaller from the larger so operand order is irrelevant.
            dx_d = (a_x >= b_x) ? (a_x - b_x) : (b_x - a_x);
            dy_d = (a_y >= b_y) ? (a_y - b_y) : (b_y - a_y);
        end
        if (sq_en) begin
            // Widen before multiplying so neither product nor sum is truncated.
            rad_d = RAD_W'(dx_q) * RAD_W'(dx_q) + RAD_W'(dy_q) * RAD_W'(dy_q);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dx_q  <= '0;
            dy_q  <= '0;
            rad_q <= '0;
        end else begin
            dx_q  <= dx_d;
            dy_q  <= dy_d;
            rad_q <= rad_d;
        end
    end

    assign radicand = rad_q;

endmodule

// File: rtl/sqrt_request.sv
// ---------------------------------------------------------------------------
// sqrt_request
// Sequences a distance computation between a tracked target and a light
// fixture, then launches an external square-root core with dx^2 + dy^2 and
// waits for its ready strobe. Requests arriving while busy are held in a
// one-deep pending buffer (latest wins).
//
// Ports:
//   clk, reset                  clock / asynchronous active-low reset
//   target_x, target_y          tracked-object position
//   light_x, light_y            fixture floor-projection position
//   target_valid                one-cycle strobe, coordinate inputs valid
//   sqrt_ready                  core result-ready strobe (honoured in WAIT only)
//   sqrt_start                  one-cycle launch strobe to the core
//   sqrt_radicand               dx^2 + dy^2, stable from LAUNCH through WAIT
//   busy                        high in every state but IDLE
//   overrun                     pulse: a pending request was overwritten
//   timeout                     pulse: WAIT abandoned after TIMEOUT_CYCLES
//
// Build option: define SQRT_REQUEST_TIMEOUT_EN to enable the WAIT-state
// timeout counter; without it WAIT waits indefinitely and timeout is 0.
// ---------------------------------------------------------------------------
module sqrt_request
    import sqrt_request_pkg::*;
#(
    parameter int COORD_W        = COORD_W_DEF,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [COORD_W-1:0]   target_x,
    input  logic [COORD_W-1:0]   target_y,
    input  logic [COORD_W-1:0]   light_x,
    input  logic [COORD_W-1:0]   light_y,
    input  logic                 target_valid,
    input  logic                 sqrt_ready,
    output logic                 sqrt_start,
    output logic [2*COORD_W:0]   sqrt_radicand,
    output logic                 busy,
    output logic                 overrun,
    output logic                 timeout
);

    typedef logic [3:0][COORD_W-1:0] coords_t;

    coords_t in_coords;
    coords_t cur_q, cur_d;           // request being computed
    coords_t pend_q, pend_d;         // one-deep pending buffer
    state_e  state_q, state_d;
    logic    pend_vld_q, pend_vld_d;
    logic    ovr_seen_q, ovr_seen_d; // overrun already reported for this pending entry
    logic    start_q, start_d;
    logic    busy_q, busy_d;
    logic    overrun_q, overrun_d;
    logic    wait_exit;
    logic    diff_en, sq_en;

`ifdef SQRT_REQUEST_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_q, timeout_d;
`endif

    always_comb begin
        in_coords         = '0;
        in_coords[IDX_TX] = target_x;
        in_coords[IDX_TY] = target_y;
        in_coords[IDX_LX] = light_x;
        in_coords[IDX_LY] = light_y;
    end

    always_comb begin
        state_d    = state_q;
        cur_d      = cur_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        ovr_seen_d = ovr_seen_q;
        start_d    = 1'b0;
        overrun_d  = 1'b0;
        wait_exit  = 1'b0;
        diff_en    = 1'b0;
        sq_en      = 1'b0;
`ifdef SQRT_REQUEST_TIMEOUT_EN
        cnt_d      = cnt_q;
        timeout_d  = 1'b0;
`endif

        case (state_q)
            ST_IDLE: begin
                if (target_valid) begin
                    cur_d   = in_coords;
                    state_d = ST_DIFF;
                end
            end
            ST_DIFF: begin
                diff_en = 1'b1;
                state_d = ST_SQUARE;
            end
            ST_SQUARE: begin
                // Radicand and start strobe both land on entry to LAUNCH.
                sq_en   = 1'b1;
                start_d = 1'b1;
                state_d = ST_LAUNCH;
            end
            ST_LAUNCH: begin
                state_d = ST_WAIT;
`ifdef SQRT_REQUEST_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            ST_WAIT: begin
`ifdef SQRT_REQUEST_TIMEOUT_EN
                if (sqrt_ready) begin
                    wait_exit = 1'b1;
                end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    wait_exit = 1'b1;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`else
                wait_exit = sqrt_ready;
`endif
            end
            default: state_d = ST_IDLE;
        endcase

        // Requests while busy go to the pending buffer; latest wins. Overrun is
        // reported once per pending entry so a burst of overwrites gives one pulse.
        if (state_q != ST_IDLE && target_valid) begin
            pend_d     = in_coords;
            pend_vld_d = 1'b1;
            if (pend_vld_q && !ovr_seen_q) begin
                overrun_d  = 1'b1;
                ovr_seen_d = 1'b1;
            end
        end

        // A strobe arriving on the exit cycle counts as pending and, being the
        // newest, is the one that gets computed next.
        if (wait_exit) begin
            if (pend_vld_q || target_valid) begin
                cur_d      = target_valid ? in_coords : pend_q;
                pend_vld_d = 1'b0;
                ovr_seen_d = 1'b0;
                state_d    = ST_DIFF;
            end else begin
                state_d    = ST_IDLE;
            end
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            cur_q      <= '0;
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            ovr_seen_q <= 1'b0;
            start_q    <= 1'b0;
            busy_q     <= 1'b0;
            overrun_q  <= 1'b0;
`ifdef SQRT_REQUEST_TIMEOUT_EN
            cnt_q      <= '0;
            timeout_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cur_q      <= cur_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            ovr_seen_q <= ovr_seen_d;
            start_q    <= start_d;
            busy_q     <= busy_d;
            overrun_q  <= overrun_d;
`ifdef SQRT_REQUEST_TIMEOUT_EN
            cnt_q      <= cnt_d;
            timeout_q  <= timeout_d;
`endif
        end
    end

    dist_sq #(
        .COORD_W (COORD_W)
    ) u_dist_sq (
        .clk      (clk),
        .reset    (reset),
        .diff_en  (diff_en),
        .sq_en    (sq_en),
        .a_x      (cur_q[IDX_TX]),
        .a_y      (cur_q[IDX_TY]),
        .b_x      (cur_q[IDX_LX]),
        .b_y      (cur_q[IDX_LY]),
        .radicand (sqrt_radicand)
    );

    assign sqrt_start = start_q;
    assign busy       = busy_q;
    assign overrun    = overrun_q;
`ifdef SQRT_REQUEST_TIMEOUT_EN
    assign timeout    = timeout_q;
`else
    assign timeout    = 1'b0;
`endif

endmodule

// File: doc/sqrt_request.md
SQRT_REQUEST -- requirements
Module: sqrt_request

Interface
REQ-001 SHALL have parameter COORD_W, default 10, pixel coordinate width.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 64, maximum WAIT-state cycles before abort.
REQ-003 SHALL have port clk  input  1  single system clock; all state on posedge clk.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have ports target_x, target_y  input  COORD_W  tracked-object position.
REQ-006 SHALL have ports light_x, light_y  input  COORD_W  fixture floor-projection position.
REQ-007 SHALL have port target_valid  input  1  one-cycle strobe: target/light inputs valid.
REQ-008 SHALL have port sqrt_ready  input  1  square-root core result-ready strobe.
REQ-009 SHALL have port sqrt_start  output  1  one-cycle launch strobe to the square-root core.
REQ-010 SHALL have port sqrt_radicand  output  2*COORD_W+1  dx^2+dy^2 presented to the core.
REQ-011 SHALL have ports busy, overrun, timeout  output  1 each  status; overrun and timeout are one-cycle pulses.

Function
REQ-012 SHALL implement FSM states IDLE, DIFF, SQUARE, LAUNCH, WAIT.
REQ-013 In IDLE, target_valid=1 SHALL latch all four coordinates; next state DIFF.
REQ-014 DIFF SHALL register dx=|target_x-light_x| and dy=|target_y-light_y| as unsigned COORD_W values, correct for either operand order.
REQ-015 SQUARE SHALL register sqrt_radicand = dx*dx + dy*dy at full 2*COORD_W+1 width, with no truncation or saturation.
REQ-016 LAUNCH SHALL drive sqrt_start=1 for exactly one cycle; next state WAIT.
REQ-017 Latency SHALL be: target_valid sampled in IDLE at cycle N, sqrt_start high at cycle N+3.
REQ-018 sqrt_radicand SHALL hold stable from LAUNCH until the cycle after leaving WAIT.
REQ-019 In WAIT, sqrt_ready=1 SHALL return the FSM to IDLE on the next cycle; sqrt_ready in any other state SHALL be ignored.
REQ-020 busy SHALL be 1 in every state except IDLE.
REQ-021 target_valid while busy SHALL store coordinates in a one-deep pending buffer and set a pending flag.
REQ-022 target_valid while the pending flag is already set SHALL overwrite the buffer (latest wins) and pulse overrun for one cycle.
REQ-023 On WAIT exit with the pending flag set, the FSM SHALL go directly to DIFF using the buffered coordinates and clear the pending flag.
REQ-024 target_valid in the same cycle as WAIT exit SHALL be treated as pending, not dropped.

Reset
REQ-025 Reset assertion SHALL asynchronously force state to IDLE and clear all registers: sqrt_start=0, sqrt_radicand=0, busy=0, overrun=0, timeout=0, pending flag=0, timeout counter=0.
REQ-026 Reset mid-operation SHALL abandon the request; no sqrt_start SHALL follow release without a new target_valid.
REQ-027 Outputs SHALL change only on clk edges after reset deassertion.

Configuration
REQ-028 Macro SQRT_REQUEST_TIMEOUT_EN defined: WAIT SHALL count cycles; if TIMEOUT_CYCLES elapse without sqrt_ready, the block SHALL pulse timeout for one cycle and leave WAIT as if ready (pending rules apply).
REQ-029 Macro SQRT_REQUEST_TIMEOUT_EN undefined: WAIT SHALL wait indefinitely, timeout SHALL be tied to 0, and no counter logic SHALL exist.

Structure
REQ-030 FSM state encoding, COORD_W default, and radicand-width constant SHALL live in the shared tracking package.
REQ-031 The distance-squared datapath (abs-diff plus square-and-sum) SHALL be one sub-module, dist_sq; the FSM and pending buffer SHALL stay at top level.

Verification
REQ-032 Target (300,200), light (100,50), valid -> sqrt_start at +3 cycles, radicand 62500.
REQ-033 Target (100,50), light (300,200) -> radicand 62500 (abs-diff symmetry).
REQ-034 Target (1023,1023), light (0,0) -> radicand 2093058, no overflow; target equals light -> radicand 0.
REQ-035 Three valids during WAIT, then sqrt_ready -> exactly one overrun pulse; next launch uses the third coordinates.
REQ-036 With macro defined, no sqrt_ready for 64 WAIT cycles -> one timeout pulse, FSM in IDLE, busy=0.
REQ-037 Reset asserted during WAIT -> all outputs 0 immediately; no sqrt_start after release.
